axi4_stream_write_dma_v2: RTL and testbench
===========================================

// Module: axi4_stream_write_dma_v2
// PURPOSE
//  Successor to the single-burst write DMA. Packs an AXIS_DATA_WIDTH stream into
//  AXI_DATA_WIDTH beats and writes them to DDR through the XPM_NMU AXI4 master.
//  Supports 4KB-safe burst splitting, up to MAX_OUTSTANDING un-acked bursts,
//  partial final beats via WSTRB, and early TLAST termination with zero-strobe padding.
// PARAMETERS
//  AXI_ADDR_WIDTH   64   AXI address width
//  AXI_DATA_WIDTH   128  AXI data width; must be an integer multiple of AXIS_DATA_WIDTH
//  AXI_ID_WIDTH     1    AWID/BID width; AWID is driven 0
//  AXIS_DATA_WIDTH  32   input stream width
//  MAX_BURST_LEN    256  maximum beats per burst (1..256)
//  MAX_OUTSTANDING  4    maximum bursts issued on AW with no B response yet (1..16)
// PORTS
//  aclk             in   1   clock
//  aresetn          in   1   reset, synchronous, active-low
//  start            in   1   1-cycle pulse; accepted only while busy=0
//  start_addr       in   AW  byte address; must be AXI_DATA_WIDTH/8 aligned
//  transfer_length  in   32  bytes; must be a multiple of AXIS_DATA_WIDTH/8
//  busy             out  1   high from accepted start until the cycle done pulses
//  done             out  1   1-cycle pulse on completion
//  error            out  1   sticky: any BRESP!=OKAY in the current transfer; cleared on start
//  bytes_written    out  32  stream bytes accepted (excludes padding); valid when done pulses
//  s_axis_*         in/out   tdata[AXIS_DATA_WIDTH], tvalid, tlast, tready
//  m_axi_aw*/w*/b*  AXI4 write channels (awid, awaddr, awlen, awsize, awburst, awlock,
//                   awcache, awprot, awqos, awvalid/ready; wdata, wstrb, wlast,
//                   wvalid/ready; bid, bresp, bvalid/ready)
// BEHAVIOUR
//  Reset: every output 0; awsize=log2(BPB), awburst=INCR, awcache=4'b0011; all counters
//   cleared. Reset mid-transfer abandons it silently, with no done pulse.
//  BPB=AXI_DATA_WIDTH/8; WPB=AXI_DATA_WIDTH/AXIS_DATA_WIDTH.
//  States: IDLE -> ADDR -> DATA -> (ADDR | DRAIN) -> DONE -> IDLE.
//  IDLE: on start, latch addr/len, clear error and bytes_written, set busy, enter ADDR.
//   If transfer_length==0, enter DONE directly (no AXI traffic).
//  ADDR: wait until outstanding<MAX_OUTSTANDING.
//   Then beats = min(MAX_BURST_LEN, ceil(bytes_rem/BPB), (4096-addr[11:0])/BPB).
//   Drive awvalid=1 and awlen=beats-1, and hold both until awready.
//   On the AW handshake: outstanding++ and enter DATA.
//  DATA: s_axis_tready = !pad && words_left>0 && (!wvalid || wready) (combinational).
//   Word k of a beat goes to lanes [k*AXIS_W +: AXIS_W], little-endian order.
//   A beat is emitted (wvalid=1, registered) when any of these holds:
//    WPB words are packed; the transfer's final word is accepted; TLAST is accepted.
//   wstrb sets bits [0 .. packed_words*AXIS_W/8-1] only.
//   wlast=1 on beat number awlen of the burst.
//   If TLAST arrives before the burst's final beat, set pad=1. The remaining beats of that
//   burst then go out with wstrb=0 and wdata=0, and no further bursts are issued.
//   At wlast handshake: if more bytes remain and !pad, enter ADDR; otherwise enter DRAIN.
//  B channel: bready=1 whenever busy. Each bvalid decrements outstanding and ORs
//   (bresp!=0) into error. B handshakes are accepted in every state, including the cycle
//   an AW handshakes (then outstanding is unchanged net).
//  DRAIN: wait until outstanding==0, then enter DONE. An error does not abort the transfer.
//  DONE: done=1 for one cycle, busy=0, return to IDLE.
//   Stream words beyond transfer_length are not accepted (tready stays 0).
//  Address advances by beats*BPB per burst.
//  bytes_written counts accepted words * AXIS_W/8.
// TESTING
//  1. len=64, addr=0x1000, 16 words, no TLAST -> one AW with awlen=3; 4 full-strobe beats;
//     done; bytes_written=64.
//  2. addr=0x0FE0, len=128 -> AW#1 0x0FE0 awlen=1, AW#2 0x1000 awlen=5; no burst crosses 4KB.
//  3. len=40 (10 words) -> awlen=2; last beat wstrb=16'h00FF; bytes_written=40.
//  4. len=256, TLAST on word 6 -> AW awlen=15; beat1 wstrb=16'h00FF; beats 2-15 wstrb=0;
//     only one AW; bytes_written=24.
//  5. MAX_BURST_LEN=4, len=1024, bvalid held 0 -> AW stalls after 4 bursts (outstanding=4);
//     releasing B resumes; done after 16 B handshakes.
//  6. bresp=SLVERR on burst 2 of 4 -> all 4 bursts complete; done with error=1;
//     next start clears error.

Source files
------------

// File: rtl/axi4_stream_write_dma_v2.sv
// Stream-to-AXI4 write DMA: packs AXIS words into AXI beats, splits bursts at 4KB
// boundaries, keeps up to MAX_OUTSTANDING bursts in flight and pads after early TLAST.

module axi4_stream_write_dma_v2_lane #(
  parameter int W = 32
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_wr,
  input  logic         i_clr,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_next
);
  logic [W-1:0] r_word;

  always_ff @(posedge aclk) begin
    if (!aresetn)   r_word <= '0;
    else if (i_clr) r_word <= '0;
    else if (i_wr)  r_word <= i_data;
  end

  // Bypass so the word accepted this cycle can complete the beat immediately
  assign o_next = i_wr ? i_data : r_word;
endmodule

module axi4_stream_write_dma_v2 #(
  parameter int AXI_ADDR_WIDTH  = 64,
  parameter int AXI_DATA_WIDTH  = 128,
  parameter int AXI_ID_WIDTH    = 1,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int MAX_BURST_LEN   = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  input  logic [AXI_ADDR_WIDTH-1:0]   start_addr,
  input  logic [31:0]                 transfer_length,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [31:0]                 bytes_written,
  input  logic [AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic                        m_axi_awlock,
  output logic [3:0]                  m_axi_awcache,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awqos,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready
);
  localparam int BPB    = AXI_DATA_WIDTH / 8;
  localparam int WPB    = AXI_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int AXIS_B = AXIS_DATA_WIDTH / 8;
  localparam int SZ     = $clog2(BPB);
  localparam int WSH    = $clog2(AXIS_B);
  localparam int PCW    = $clog2(WPB + 1);
  localparam int OCW    = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DRAIN, ST_DONE} state_t;

  state_t                      r_state;
  logic                        r_busy, r_done, r_error, r_pad;
  logic [31:0]                 r_bytes_written, r_bytes_rem, r_words_left;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic                        r_awvalid;
  logic [7:0]                  r_awlen;
  logic [8:0]                  r_burst_beats, r_beat_cnt;
  logic [OCW-1:0]              r_out;
  logic [PCW-1:0]              r_pack_cnt;
  logic                        r_wvalid, r_wlast;
  logic [AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [BPB-1:0]              r_wstrb;

  logic [32:0] w_rem_beats, w_beats_full;
  logic [12:0] w_4k_beats;
  logic [8:0]  w_beats;
  logic [31:0] w_burst_bytes;
  logic        w_acc, w_wfree, w_emit_word, w_emit_pad, w_last_beat;
  logic        w_aw_hs, w_whs, w_wlast_hs, w_b_hs, w_unused;
  logic [PCW-1:0] w_new_cnt;
  logic [WPB-1:0][AXIS_DATA_WIDTH-1:0] w_beat_data;
  logic [BPB-1:0] w_strb;

  // Burst length: limited by remaining bytes, the 4KB page and MAX_BURST_LEN
  assign w_rem_beats = ({1'b0, r_bytes_rem} + 33'(BPB - 1)) >> SZ;
  assign w_4k_beats  = (13'd4096 - {1'b0, r_addr[11:0]}) >> SZ;
  always_comb begin
    w_beats_full = 33'(MAX_BURST_LEN);
    if (w_rem_beats < w_beats_full)      w_beats_full = w_rem_beats;
    if (33'(w_4k_beats) < w_beats_full) w_beats_full = 33'(w_4k_beats);
  end
  assign w_beats       = w_beats_full[8:0];
  assign w_burst_bytes = 32'(r_burst_beats) << SZ;

  assign w_wfree       = !r_wvalid || m_axi_wready;
  assign s_axis_tready = (r_state == ST_DATA) && !r_pad && (r_words_left != 32'd0) &&
                         (r_beat_cnt < r_burst_beats) && w_wfree;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  assign w_new_cnt     = r_pack_cnt + PCW'(1);
  assign w_emit_word   = w_acc && ((w_new_cnt == PCW'(WPB)) || (r_words_left == 32'd1) || s_axis_tlast);
  assign w_emit_pad    = (r_state == ST_DATA) && r_pad && (r_beat_cnt < r_burst_beats) && w_wfree;
  assign w_last_beat   = (r_beat_cnt == r_burst_beats - 9'd1);
  assign w_aw_hs       = r_awvalid && m_axi_awready;
  assign w_whs         = r_wvalid && m_axi_wready;
  assign w_wlast_hs    = w_whs && r_wlast;
  assign w_b_hs        = m_axi_bvalid && r_busy;

  genvar k;
  generate
    for (k = 0; k < WPB; k++) begin : g_lane
      axi4_stream_write_dma_v2_lane #(.W(AXIS_DATA_WIDTH)) u_lane (
        .aclk    (aclk),
        .aresetn (aresetn),
        .i_wr    (w_acc && (r_pack_cnt == PCW'(k))),
        .i_clr   (w_emit_word),
        .i_data  (s_axis_tdata),
        .o_next  (w_beat_data[k])
      );
      assign w_strb[k*AXIS_B +: AXIS_B] = {AXIS_B{PCW'(k) < w_new_cnt}};
    end
  endgenerate

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state         <= ST_IDLE;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
      r_pad           <= 1'b0;
      r_bytes_written <= '0;
      r_bytes_rem     <= '0;
      r_words_left    <= '0;
      r_addr          <= '0;
      r_awvalid       <= 1'b0;
      r_awlen         <= '0;
      r_burst_beats   <= '0;
      r_beat_cnt      <= '0;
      r_out           <= '0;
      r_pack_cnt      <= '0;
      r_wvalid        <= 1'b0;
      r_wlast         <= 1'b0;
      r_wdata         <= '0;
      r_wstrb         <= '0;
    end else begin
      r_done <= 1'b0;
      r_out  <= r_out + OCW'(w_aw_hs) - OCW'(w_b_hs);
      if (w_b_hs && (m_axi_bresp != 2'b00)) r_error <= 1'b1;

      if (w_emit_word || w_emit_pad) begin
        r_wvalid   <= 1'b1;
        r_wdata    <= w_emit_word ? w_beat_data : '0;
        r_wstrb    <= w_emit_word ? w_strb : '0;
        r_wlast    <= w_last_beat;
        r_beat_cnt <= r_beat_cnt + 9'd1;
      end else if (w_whs) begin
        r_wvalid <= 1'b0;
      end

      if (w_acc) begin
        r_words_left    <= r_words_left - 32'd1;
        r_bytes_written <= r_bytes_written + 32'(AXIS_B);
        r_pack_cnt      <= w_emit_word ? '0 : w_new_cnt;
        if (s_axis_tlast) r_pad <= 1'b1;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (start) begin
            r_addr          <= start_addr;
            r_bytes_rem     <= transfer_length;
            r_words_left    <= transfer_length >> WSH;
            r_error         <= 1'b0;
            r_bytes_written <= '0;
            r_pad           <= 1'b0;
            r_pack_cnt      <= '0;
            if (transfer_length == 32'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ADDR;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (!r_awvalid) begin
            if (r_out < OCW'(MAX_OUTSTANDING)) begin
              r_awvalid     <= 1'b1;
              r_awlen       <= 8'(w_beats - 9'd1);
              r_burst_beats <= w_beats;
            end
          end else if (m_axi_awready) begin
            r_awvalid   <= 1'b0;
            r_addr      <= r_addr + (AXI_ADDR_WIDTH'(r_burst_beats) << SZ);
            r_bytes_rem <= (r_bytes_rem > w_burst_bytes) ? r_bytes_rem - w_burst_bytes : 32'd0;
            r_beat_cnt  <= '0;
            r_state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_wlast_hs) r_state <= ((r_bytes_rem != 32'd0) && !r_pad) ? ST_ADDR : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (r_out == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign bytes_written = r_bytes_written;
  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = r_wlast;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_busy;

  assign w_unused = &{1'b0, m_axi_bid, w_beats_full[32:9]};
endmodule

// File: tb/tb_axi4_stream_write_dma_v2.sv
// Bench for axi4_stream_write_dma_v2: directed table, corner sequences and random
// transfers checked against a burst/beat reference model.
module tb_axi4_stream_write_dma_v2;
  localparam int MBL = 16, MO = 4, BPB = 16, WPB = 4;

  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic start = 0, busy, done, error;
  logic [63:0] start_addr = 0;
  logic [31:0] transfer_length = 0, bytes_written;
  logic [31:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tready;
  logic [0:0] m_axi_awid, m_axi_bid = 0;
  logic [63:0] m_axi_awaddr;
  logic [7:0] m_axi_awlen;
  logic [2:0] m_axi_awsize, m_axi_awprot;
  logic [1:0] m_axi_awburst, m_axi_bresp = 0;
  logic m_axi_awlock, m_axi_awvalid, m_axi_awready = 0;
  logic [3:0] m_axi_awcache, m_axi_awqos;
  logic [127:0] m_axi_wdata;
  logic [15:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready = 0, m_axi_bvalid = 0, m_axi_bready;

  axi4_stream_write_dma_v2 #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(128), .AXI_ID_WIDTH(1),
    .AXIS_DATA_WIDTH(32), .MAX_BURST_LEN(MBL), .MAX_OUTSTANDING(MO)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .start_addr(start_addr),
    .transfer_length(transfer_length), .busy(busy), .done(done), .error(error),
    .bytes_written(bytes_written), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready), .m_axi_awid(m_axi_awid),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready));

  typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
  typedef struct { logic [127:0] data; logic [15:0] strb; logic last; } w_t;
  typedef struct { logic [31:0] d; logic l; } src_t;
  typedef struct { logic [63:0] addr; int len; int tlast_at; int err_burst; int extra;
                   int exp_naw; int exp_awlen0; int exp_bytes; int exp_err; } vec_t;

  aw_t got_aw[$], exp_aw[$];
  w_t  got_w[$], exp_w[$];
  src_t src_q[$];
  logic [1:0] bq[$];
  logic [31:0] wd[$];
  int n_chk = 0, n_pass = 0;
  int n_b, nb_w, n_acc, n_done, max_out, err_burst = -1, exp_bytes;
  logic [31:0] done_bytes;
  logic done_err;
  bit hs_s, hs_aw, hs_w, hs_b, src_flush = 0, b_en = 1;

  // Handshake monitor: values are stable half a cycle before the edge that takes them
  always @(negedge aclk) begin
    hs_s  = s_axis_tvalid && s_axis_tready;
    hs_aw = m_axi_awvalid && m_axi_awready;
    hs_w  = m_axi_wvalid && m_axi_wready;
    hs_b  = m_axi_bvalid && m_axi_bready;
    if (aresetn) begin
      if (hs_aw) got_aw.push_back('{m_axi_awaddr, m_axi_awlen});
      if (hs_w) begin
        got_w.push_back('{m_axi_wdata, m_axi_wstrb, m_axi_wlast});
        if (m_axi_wlast) begin
          bq.push_back((nb_w == err_burst) ? 2'b10 : 2'b00);
          nb_w++;
        end
      end
      if (hs_s) n_acc++;
      if (hs_b) n_b++;
      if (got_aw.size() - n_b > max_out) max_out = got_aw.size() - n_b;
      if (done) begin n_done++; done_bytes = bytes_written; done_err = error; end
    end
  end

  // Stream source and AXI slave responders
  always begin
    @(posedge aclk); #1;
    if (src_flush) begin
      src_q.delete(); s_axis_tvalid = 0; bq.delete(); m_axi_bvalid = 0;
    end else begin
      if (hs_s) begin src_q.delete(0); s_axis_tvalid = 0; end
      if (!s_axis_tvalid && src_q.size() > 0 && $urandom_range(3) != 0) begin
        s_axis_tvalid = 1; s_axis_tdata = src_q[0].d; s_axis_tlast = src_q[0].l;
      end
      if (hs_b) m_axi_bvalid = 0;
      if (!m_axi_bvalid && b_en && bq.size() > 0 && $urandom_range(1) == 1) begin
        m_axi_bvalid = 1; m_axi_bresp = bq.pop_front();
      end
    end
    m_axi_awready = ($urandom_range(2) != 0);
    m_axi_wready  = ($urandom_range(3) != 0);
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: bursts from the sizing rule, beats from word positions in the stream
  task automatic model(input logic [63:0] addr, input int len, input int tlast_at);
    int words, nacc, gbeat, rem, beats, b4k;
    logic [63:0] a;
    w_t w;
    exp_aw.delete(); exp_w.delete();
    words = len / 4;
    nacc = (tlast_at >= 0 && tlast_at < words) ? tlast_at + 1 : words;
    exp_bytes = nacc * 4;
    a = addr; rem = len; gbeat = 0;
    while (rem > 0) begin
      beats = (rem + BPB - 1) / BPB;
      if (beats > MBL) beats = MBL;
      b4k = (4096 - int'(a[11:0])) / BPB;
      if (b4k < beats) beats = b4k;
      exp_aw.push_back('{a, 8'(beats - 1)});
      for (int i = 0; i < beats; i++) begin
        w.data = '0; w.strb = '0; w.last = (i == beats - 1);
        for (int j = 0; j < WPB; j++)
          if (gbeat * WPB + j < nacc) begin
            w.data[j*32 +: 32] = wd[gbeat * WPB + j]; w.strb[j*4 +: 4] = 4'hF;
          end
        exp_w.push_back(w); gbeat++;
      end
      a += 64'(beats * BPB);
      rem = (rem > beats * BPB) ? rem - beats * BPB : 0;
      if (nacc < words && gbeat * WPB >= nacc) rem = 0;
    end
  endtask

  task automatic launch(input vec_t v);
    int words, nsend;
    logic [31:0] d;
    got_aw.delete(); got_w.delete(); bq.delete(); wd.delete();
    n_b = 0; nb_w = 0; n_acc = 0; n_done = 0; max_out = 0; err_burst = v.err_burst;
    words = v.len / 4;
    nsend = (v.tlast_at >= 0 && v.tlast_at < words) ? v.tlast_at + 1 : words + v.extra;
    for (int i = 0; i < nsend; i++) begin
      d = $urandom; wd.push_back(d); src_q.push_back('{d, (i == v.tlast_at)});
    end
    model(v.addr, v.len, v.tlast_at);
    @(posedge aclk); #1;
    start = 1; start_addr = v.addr; transfer_length = 32'(v.len);
    @(posedge aclk); #1;
    start = 0;
    @(negedge aclk);
    if (v.len != 0) chk("busy_after_start", busy, 1);
    chk("error_cleared_on_start", error, 0);
  endtask

  task automatic finish_check(input vec_t v, input string nm);
    int cyc = 0;
    while (n_done == 0 && cyc < 20000) begin @(posedge aclk); cyc++; end
    chk({nm, " done_seen"}, n_done != 0, 1);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk({nm, " aw_count"}, got_aw.size(), exp_aw.size());
    for (int i = 0; i < got_aw.size() && i < exp_aw.size(); i++) begin
      chk({nm, " aw"}, {got_aw[i].addr, got_aw[i].len}, {exp_aw[i].addr, exp_aw[i].len});
      chk({nm, " 4k"}, (int'(got_aw[i].addr[11:0]) + (int'(got_aw[i].len) + 1) * BPB) <= 4096, 1);
    end
    chk({nm, " w_count"}, got_w.size(), exp_w.size());
    for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
      chk({nm, " w_beat{strb,last,data}"}, {got_w[i].strb, got_w[i].last, got_w[i].data},
          {exp_w[i].strb, exp_w[i].last, exp_w[i].data});
    chk({nm, " words_accepted"}, n_acc, exp_bytes / 4);
    chk({nm, " bytes_written"}, done_bytes, exp_bytes);
    chk({nm, " error"}, done_err, (v.err_burst >= 0 && v.err_burst < exp_aw.size()));
    chk({nm, " b_count"}, n_b, exp_aw.size());
    chk({nm, " single_done"}, n_done, 1);
    chk({nm, " max_outstanding"}, max_out <= MO, 1);
    chk({nm, " idle_busy"}, busy, 0);
    if (v.exp_naw >= 0) begin
      chk({nm, " tbl_naw"}, got_aw.size(), v.exp_naw);
      if (v.exp_naw > 0 && got_aw.size() > 0) chk({nm, " tbl_awlen0"}, got_aw[0].len, v.exp_awlen0);
      chk({nm, " tbl_bytes"}, done_bytes, v.exp_bytes);
      chk({nm, " tbl_error"}, done_err, v.exp_err);
    end
    src_flush = 1; repeat (2) @(posedge aclk); #1; src_flush = 0;
  endtask

  vec_t tbl[9];
  vec_t v;
  int cyc;

  initial begin
    //        addr        len  tlast err extra naw awlen0 bytes err
    tbl[0] = '{64'h1000,   64,  -1,  -1, 0,   1,  3,    64,   0};
    tbl[1] = '{64'h0FE0,  128,  -1,  -1, 0,   2,  1,    128,  0};
    tbl[2] = '{64'h2000,   40,  -1,  -1, 0,   1,  2,    40,   0};
    tbl[3] = '{64'h3000,  256,   5,  -1, 0,   1,  15,   24,   0};
    tbl[4] = '{64'h8000, 1024,  -1,   1, 0,   4,  15,   1024, 1};
    tbl[5] = '{64'h0,       0,  -1,  -1, 0,   0,  0,    0,    0};
    tbl[6] = '{64'h5000,   48,  -1,  -1, 3,   1,  2,    48,   0};
    tbl[7] = '{64'h1F00,  512,  -1,  -1, 0,   2,  15,   512,  0};
    tbl[8] = '{64'h6000,  512,  63,  -1, 0,   1,  15,   256,  0};

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("reset busy/done/error/bytes", {busy, done, error, bytes_written}, 0);
    chk("reset valids/readies", {m_axi_awvalid, m_axi_wvalid, s_axis_tready, m_axi_bready}, 0);
    chk("reset aw constants", {m_axi_awsize, m_axi_awburst, m_axi_awcache}, {3'd4, 2'b01, 4'b0011});
    @(posedge aclk); #1; aresetn = 1;

    for (int i = 0; i < 9; i++) begin
      launch(tbl[i]);
      finish_check(tbl[i], $sformatf("tbl%0d", i));
    end

    // Outstanding limit: B withheld, AW must stop at MO bursts
    v = '{64'h10000, 2048, -1, -1, 0, 8, 15, 2048, 0};
    b_en = 0;
    launch(v);
    cyc = 0;
    while (got_w.size() < MO * MBL && cyc < 5000) begin @(posedge aclk); cyc++; end
    repeat (50) @(posedge aclk);
    @(negedge aclk);
    chk("stall aw_count", got_aw.size(), MO);
    chk("stall awvalid", m_axi_awvalid, 0);
    chk("stall b_count", n_b, 0);
    chk("stall busy", busy, 1);
    b_en = 1;
    finish_check(v, "stall");

    // Reset mid-transfer: abandoned silently
    v = '{64'h20000, 512, -1, -1, 0, -1, 0, 0, 0};
    launch(v);
    repeat (40) @(posedge aclk);
    #1; aresetn = 0; src_flush = 1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("midreset outputs", {busy, done, m_axi_awvalid, m_axi_wvalid, s_axis_tready}, 0);
    @(posedge aclk); #1; aresetn = 1; src_flush = 0; n_done = 0;
    repeat (50) @(posedge aclk);
    chk("midreset no_done", n_done, 0);

    for (int i = 0; i < 24; i++) begin
      v.addr = (64'($urandom_range(0, 3)) << 32) | (64'($urandom_range(0, 4095)) << 4);
      v.len = 4 * $urandom_range(1, 300);
      v.tlast_at = ($urandom_range(3) == 0) ? $urandom_range(0, v.len / 4 - 1) : -1;
      v.err_burst = ($urandom_range(4) == 0) ? $urandom_range(0, 3) : -1;
      v.extra = $urandom_range(0, 2);
      v.exp_naw = -1;
      launch(v);
      finish_check(v, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
